// File: rtl/text_pkg.sv
// Shared definitions for the character-cell text panels: the glyph code map,
// the character code width and the snapshot FSM state type.
package text_pkg;

  localparam int CHAR_W = 6;

  localparam logic [CHAR_W-1:0] CH_HEX0  = 6'd0;
  localparam logic [CHAR_W-1:0] CH_HEX1  = 6'd1;
  localparam logic [CHAR_W-1:0] CH_HEX2  = 6'd2;
  localparam logic [CHAR_W-1:0] CH_HEX3  = 6'd3;
  localparam logic [CHAR_W-1:0] CH_HEX4  = 6'd4;
  localparam logic [CHAR_W-1:0] CH_HEX5  = 6'd5;
  localparam logic [CHAR_W-1:0] CH_HEX6  = 6'd6;
  localparam logic [CHAR_W-1:0] CH_HEX7  = 6'd7;
  localparam logic [CHAR_W-1:0] CH_HEX8  = 6'd8;
  localparam logic [CHAR_W-1:0] CH_HEX9  = 6'd9;
  localparam logic [CHAR_W-1:0] CH_HEXA  = 6'd10;
  localparam logic [CHAR_W-1:0] CH_HEXB  = 6'd11;
  localparam logic [CHAR_W-1:0] CH_HEXC  = 6'd12;
  localparam logic [CHAR_W-1:0] CH_HEXD  = 6'd13;
  localparam logic [CHAR_W-1:0] CH_HEXE  = 6'd14;
  localparam logic [CHAR_W-1:0] CH_HEXF  = 6'd15;
  localparam logic [CHAR_W-1:0] CH_R     = 6'd16;
  localparam logic [CHAR_W-1:0] CH_COLON = 6'd17;
  localparam logic [CHAR_W-1:0] CH_SPACE = 6'd18;

  typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, WRITE, DONE} state_t;

endpackage

// File: rtl/reg_text_buffer_if.sv
// Snapshot handshake, register-file read port and renderer cell port of the
// register text buffer. Optional macro: REG_TEXT_HILITE_EN adds rd_hilite.
interface reg_text_buffer_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
);
  localparam int ROW_W = $clog2(NUM_REGS);

  logic              snap_req;
  logic              busy;
  logic              snap_done;
  logic [ROW_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_data;
  logic [ROW_W-1:0]  rd_row;
  logic [3:0]        rd_col;
  logic [5:0]        rd_char;
`ifdef REG_TEXT_HILITE_EN
  logic              rd_hilite;
`endif

  // Renderer / register-file side
  modport master (
    output snap_req, reg_data, rd_row, rd_col,
`ifdef REG_TEXT_HILITE_EN
    input  rd_hilite,
`endif
    input  busy, snap_done, reg_sel, rd_char
  );

  // Text buffer side
  modport slave (
    input  snap_req, reg_data, rd_row, rd_col,
`ifdef REG_TEXT_HILITE_EN
    output rd_hilite,
`endif
    output busy, snap_done, reg_sel, rd_char
  );
endinterface

// File: rtl/text_cell_mux.sv
// Column-to-character mapping for one register row: "R", row digit, ":",
// space, then the stored hex digits; anything past the last column is blank.
module text_cell_mux
  import text_pkg::*;
#(
  parameter int ROW_W = 3,
  parameter int COLS  = 8
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [3:0]        col,
  input  logic [3:0]        digit,
  output logic [CHAR_W-1:0] code
);

  // Label columns are synthesized here; only digit columns use stored data
  always_comb begin
    code = CH_SPACE;
    case (col)
      4'd0:    code = CH_R;
      4'd1:    code = CHAR_W'(row);
      4'd2:    code = CH_COLON;
      4'd3:    code = CH_SPACE;
      default: if (32'(col) < COLS) code = CHAR_W'(digit);
    endcase
  end

endmodule

// File: rtl/reg_text_buffer.sv
// Register-file text buffer: snapshots every register into hex digit cells
// and serves the renderer one registered cell code per clock.
// Optional macro: REG_TEXT_HILITE_EN adds per-digit change flags (rd_hilite).
module reg_text_buffer
  import text_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input logic              clock,
  input logic              resetn,
  reg_text_buffer_if.slave bus
);

  localparam int ROW_W = $clog2(NUM_REGS);
  localparam int ND    = DATA_W / 4;
  localparam int COLS  = 4 + ND;
  localparam int CNT_W = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ND - 1);
  localparam logic [ROW_W-1:0] REG_LAST = ROW_W'(NUM_REGS - 1);

  state_t                        state;
  logic                          busy, snap_done;
  logic [ROW_W-1:0]              reg_sel;
  logic [CNT_W-1:0]              cnt;
  logic [DATA_W-1:0]             shreg;
  logic [NUM_REGS-1:0][ND-1:0][3:0] digits;
  logic [3:0]                    nib;
  logic [3:0]                    rd_digit;
  logic [CHAR_W-1:0]             cell_code;
  logic [CHAR_W-1:0]             rd_char;

  assign nib           = shreg[DATA_W-1 -: 4];
  assign bus.busy      = busy;
  assign bus.snap_done = snap_done;
  assign bus.reg_sel   = reg_sel;
  assign bus.rd_char   = rd_char;

  // Snapshot sequencer: reg_sel doubles as the register index and is held
  // from ADDR through the last nibble write of that register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      snap_done <= 1'b0;
      reg_sel   <= '0;
      cnt       <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.snap_req) begin
          state   <= ADDR;
          busy    <= 1'b1;
          reg_sel <= '0;
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          shreg <= bus.reg_data;
          cnt   <= '0;
          state <= WRITE;
        end
        WRITE: begin
          shreg <= shreg << 4;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (reg_sel == REG_LAST) begin
              state     <= DONE;
              snap_done <= 1'b1;
            end else begin
              reg_sel <= reg_sel + 1'b1;
              state   <= ADDR;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          snap_done <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          snap_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_TEXT_HILITE_EN
  logic [NUM_REGS-1:0][ND-1:0] flags;
  logic                        rd_flag;
  logic                        rd_hilite;
  assign bus.rd_hilite = rd_hilite;
`endif

  // Digit storage: one nibble per WRITE cycle, MSB nibble into column 4
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digits <= '0;
`ifdef REG_TEXT_HILITE_EN
      flags  <= '0;
`endif
    end else if (state == WRITE) begin
      digits[reg_sel][cnt] <= nib;
`ifdef REG_TEXT_HILITE_EN
      flags[reg_sel][cnt]  <= (nib != digits[reg_sel][cnt]);
`endif
    end
  end

  // Digit lookup for the addressed cell; label/out-of-range columns read 0
  always_comb begin
    rd_digit = '0;
`ifdef REG_TEXT_HILITE_EN
    rd_flag  = 1'b0;
`endif
    for (int j = 0; j < ND; j++) begin
      if (bus.rd_col == 4'(4 + j)) begin
        rd_digit = digits[bus.rd_row][j];
`ifdef REG_TEXT_HILITE_EN
        rd_flag  = flags[bus.rd_row][j];
`endif
      end
    end
  end

  text_cell_mux #(.ROW_W(ROW_W), .COLS(COLS)) u_mux (
    .row   (bus.rd_row),
    .col   (bus.rd_col),
    .digit (rd_digit),
    .code  (cell_code)
  );

  // Registered read port; storage is updated with <= so a same-cycle write
  // is not visible until the next read
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_char   <= CH_SPACE;
`ifdef REG_TEXT_HILITE_EN
      rd_hilite <= 1'b0;
`endif
    end else begin
      rd_char   <= cell_code;
`ifdef REG_TEXT_HILITE_EN
      rd_hilite <= rd_flag;
`endif
    end
  end

endmodule

// File: tb/tb_reg_text_buffer.sv
// Self-checking bench for reg_text_buffer: directed steps plus randomized
// register contents checked against an array model of the displayed text.
module tb_reg_text_buffer;

  localparam int NR   = 8;
  localparam int DW   = 16;
  localparam int ND   = DW / 4;
  localparam int COLS = 4 + ND;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  reg_text_buffer_if #(.NUM_REGS(NR), .DATA_W(DW)) bus();

  reg_text_buffer #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  // Register file with a one-cycle registered read
  logic [DW-1:0] regs [NR];
  always @(posedge clock) bus.reg_data <= regs[bus.reg_sel];

  int checks = 0;
  int errors = 0;
  int mdig  [NR][ND];
  bit mflag [NR][ND];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NR; r++)
      for (int d = 0; d < ND; d++) begin
        mdig[r][d]  = 0;
        mflag[r][d] = 0;
      end
  endfunction

  // A completed snapshot shows each register as hex, MSB digit first
  function automatic void apply_snap();
    for (int r = 0; r < NR; r++)
      for (int d = 0; d < ND; d++) begin
        int nv;
        nv = int'((regs[r] >> (4 * (ND - 1 - d))) & 16'hF);
        mflag[r][d] = (nv != mdig[r][d]);
        mdig[r][d]  = nv;
      end
  endfunction

  function automatic int exp_char(input int r, input int c);
    if (c == 0) return 16;
    if (c == 1) return r;
    if (c == 2) return 17;
    if (c == 3) return 18;
    if (c < COLS) return mdig[r][c-4];
    return 18;
  endfunction

  task automatic read_check(input int r, input int c, input string tag);
    @(negedge clock);
    bus.rd_row = 3'(r);
    bus.rd_col = 4'(c);
    @(negedge clock);
    chk($sformatf("%s(%0d,%0d)", tag, r, c), int'(bus.rd_char), exp_char(r, c));
`ifdef REG_TEXT_HILITE_EN
    chk($sformatf("%s_hl(%0d,%0d)", tag, r, c), int'(bus.rd_hilite),
        (c >= 4 && c < COLS) ? int'(mflag[r][c-4]) : 0);
`endif
  endtask

  task automatic run_snap(input string tag);
    int n;
    int done_at;
    n = 0;
    done_at = -1;
    @(negedge clock);
    bus.snap_req = 1'b1;
    while (n < 200) begin
      @(negedge clock);
      bus.snap_req = 1'b0;
      n++;
      if (bus.snap_done) begin
        done_at = n;
        break;
      end
      if (!bus.busy) begin
        chk({tag, "_busy"}, 0, 1);
        break;
      end
    end
    chk({tag, "_latency"}, done_at, 49);
    @(negedge clock);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_done_after"}, int'(bus.snap_done), 0);
    apply_snap();
  endtask

  initial begin
    int dones[$];
    int k;
    bit prev_busy;

    bus.snap_req = 1'b0;
    bus.rd_row   = '0;
    bus.rd_col   = '0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.snap_done), 0);
    chk("rst_sel", int'(bus.reg_sel), 0);
    chk("rst_char", int'(bus.rd_char), 18);
    resetn = 1'b1;
    read_check(3, 5, "init");

    // Basic directed snapshot
    regs[0] = 16'h1234;
    regs[5] = 16'hBEEF;
    run_snap("basic");
    for (int c = 4; c < 8; c++) read_check(0, c, "r0");
    for (int c = 4; c < 8; c++) read_check(5, c, "r5");
    read_check(5, 1, "r5idx");
    read_check(5, 2, "r5colon");
    read_check(5, 0, "r5R");
    read_check(2, 8, "oor");
    read_check(2, 15, "oor");

    // Randomized register contents
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
      run_snap($sformatf("rnd%0d", it));
      for (int j = 0; j < 16; j++)
        read_check(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 15)), "rnd");
    end

    // Held request: back-to-back snapshots, reg_sel walk
    dones.delete();
    k = 0;
    prev_busy = 1'b0;
    @(negedge clock);
    bus.snap_req = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clock);
      if (bus.busy && !prev_busy) k = 0;
      if (bus.snap_done) dones.push_back(n);
      else if (bus.busy) begin
        chk($sformatf("held_sel%0d", k), int'(bus.reg_sel), k / 6);
        k++;
      end
      prev_busy = bus.busy;
    end
    bus.snap_req = 1'b0;
    chk("held_npulses", dones.size(), 2);
    if (dones.size() >= 2) begin
      chk("held_first", dones[0], 49);
      chk("held_gap", dones[1] - dones[0], 50);
    end
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clock);
    chk("held_idle", int'(bus.busy), 0);
    repeat (3) apply_snap();
    read_check(4, 6, "held");

    // Read-during-write on cell (0,4): old digit first, new one next
    for (int i = 0; i < NR; i++) regs[i] = '0;
    run_snap("zero");
    regs[0] = 16'h1000;
    @(negedge clock);
    bus.rd_row   = 3'd0;
    bus.rd_col   = 4'd4;
    bus.snap_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      bus.snap_req = 1'b0;
      if (n == 4) chk("rdw_old", int'(bus.rd_char), 0);
      if (n == 5) chk("rdw_new", int'(bus.rd_char), 1);
    end
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clock);
    chk("rdw_idle", int'(bus.busy), 0);
    apply_snap();
    read_check(0, 4, "rdw");

    // Reset in the middle of a snapshot
    for (int i = 0; i < NR; i++) regs[i] = DW'($urandom) | 16'h1111;
    @(negedge clock);
    bus.snap_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      bus.snap_req = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.snap_done), 0);
    chk("mid_rst_sel", int'(bus.reg_sel), 0);
    chk("mid_rst_char", int'(bus.rd_char), 18);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    read_check(3, 4, "mid_rst");
    read_check(3, 0, "mid_rst");
    read_check(0, 4, "mid_rst");

`ifdef REG_TEXT_HILITE_EN
    // Change flags: A0 -> B0 flags only (2,6); a repeat clears everything
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[2] = 16'h00A0;
    run_snap("hl1");
    regs[2] = 16'h00B0;
    run_snap("hl2");
    for (int r = 0; r < NR; r++)
      for (int c = 0; c <= COLS; c++) begin
        @(negedge clock);
        bus.rd_row = 3'(r);
        bus.rd_col = 4'(c);
        @(negedge clock);
        chk($sformatf("hl_chg(%0d,%0d)", r, c), int'(bus.rd_hilite),
            (r == 2 && c == 6) ? 1 : 0);
      end
    run_snap("hl3");
    for (int r = 0; r < NR; r++)
      for (int c = 0; c <= COLS; c++) begin
        @(negedge clock);
        bus.rd_row = 3'(r);
        bus.rd_col = 4'(c);
        @(negedge clock);
        chk($sformatf("hl_same(%0d,%0d)", r, c), int'(bus.rd_hilite), 0);
      end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_text_buffer.md
Name: reg_text_buffer

Overview:
- Character-cell text buffer that sits directly upstream of the VGA character renderer.
- On a snapshot request it reads the CPU register file through a read port, one register at a time, and converts each value into hex digit character codes stored per cell.
- The renderer reads one cell at a time by (row, col) and gets back a 6-bit character code for the glyph ROM.
- Row r shows: "R", register index digit, ":", space, then DATA_W/4 hex digits, MSB nibble first.

Parameters:
- NUM_REGS, 8: registers displayed, one per text row; power of two, 2..16.
- DATA_W, 16: register width; multiple of 4, 4..32.
- COLS, 4+DATA_W/4: local parameter; number of text columns per row.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- snap_req  in  1  level request to take a snapshot of the register file.
- busy  out  1  high while a snapshot is in progress.
- snap_done  out  1  one-cycle pulse when a snapshot is complete.
- reg_sel  out  $clog2(NUM_REGS)  register file read address.
- reg_data  in  DATA_W  register file read data, valid one cycle after reg_sel.
- rd_row  in  $clog2(NUM_REGS)  renderer cell row.
- rd_col  in  4  renderer cell column.
- rd_char  out  6  character code of cell (rd_row, rd_col), registered.

Behaviour:
- Character codes: 0..15 = hex digits 0-F; 16 = 'R'; 17 = ':'; 18 = space.
- Storage: digit buffer of NUM_REGS x DATA_W/4 entries, 4 bits each. Label columns are generated, not stored.
- Reset (asynchronous): FSM goes to IDLE. busy=0, snap_done=0, reg_sel=0, rd_char=18, all stored digits=0.

FSM states and transitions:
- IDLE: snap_req sampled high moves to ADDR with reg index 0; otherwise stays in IDLE.
- ADDR: drives reg_sel = index for one cycle, then goes to CAPTURE.
- CAPTURE: latches reg_data into a shift register, then goes to WRITE with nibble count 0.
- WRITE: writes one nibble per cycle, MSB first, to buffer[index][count]. After DATA_W/4 cycles:
  - if index == NUM_REGS-1, go to DONE;
  - otherwise index+1 and go back to ADDR.
- DONE: snap_done=1 for exactly this cycle, then go to IDLE.

Timing and handshake:
- busy=1 in every state except IDLE.
- Snapshot length is NUM_REGS*(2+DATA_W/4) cycles plus 1 DONE cycle; defaults give 48+1 = 49 cycles.
- reg_sel holds its value from ADDR through the end of WRITE for that register.
- snap_req is ignored while busy. If snap_req is still high in IDLE after DONE, a new snapshot starts immediately: exactly one idle cycle between snap_done and the next busy.

Read port:
- rd_char is updated on every clock edge from rd_row/rd_col (1-cycle latency), independent of the FSM.
- Column mapping:
  - col 0 gives 16 ('R').
  - col 1 gives rd_row (zero-extended).
  - col 2 gives 17 (':').
  - col 3 gives 18 (space).
  - cols 4..COLS-1 give the stored digit.
  - col >= COLS gives 18.
- A same-cycle read and write of one cell returns the old digit (read-before-write).
- The buffer is live-updated during a snapshot: a frame may show a mix of old and new values. The renderer uses snap_done to schedule redraws.
- Reset mid-snapshot aborts the snapshot; the buffer returns to all zeros.

Optional Feature:
- Macro: REG_TEXT_HILITE_EN.
- Defined:
  - Adds output rd_hilite (1 bit), aligned with rd_char (same 1-cycle latency).
  - A per-digit flag is set when a WRITE stores a nibble different from the one it overwrites, and cleared when the same value is written.
  - The flag is 0 for label columns and out-of-range columns.
  - All flags reset to 0.
  - The renderer uses rd_hilite to draw changed digits in a highlight colour.
- Not defined: the port and flag storage are absent; all other behaviour is identical.

Decomposition:
- Shared package text_pkg holds:
  - character code constants CH_HEX0..CH_HEXF, CH_R=16, CH_COLON=17, CH_SPACE=18;
  - CHAR_W=6;
  - FSM state typedef {IDLE, ADDR, CAPTURE, WRITE, DONE}.
- The glyph ROM is updated to the same code map.
- One sub-module: text_cell_mux, the combinational col-to-code mapping (label/digit/space selection), reusable by other text panels.

Test Plan:
- Reset: assert resetn=0 mid-snapshot (cycle 20) -> busy=0, snap_done=0, reg_sel=0; reading (3,4) gives 0; reading (3,0) gives 16.
- Basic snapshot: regfile R0=0x1234, R5=0xBEEF, others 0; pulse snap_req -> snap_done exactly 49 cycles later. Reading (0,4..7) gives 1,2,3,4; (5,4..7) gives 11,14,14,15; (5,1) gives 5; (5,2) gives 17.
- Out-of-range column: read (2,8) and (2,15) -> 18 on the next cycle.
- Held request: snap_req held high for 120 cycles -> two snap_done pulses 50 cycles apart. reg_sel sequence is 0..7, each value held 6 cycles.
- Read-during-write: read cell (0,4) on the cycle it is written from 0 to 1 -> old value 0 returned, then 1 on the following read.
- Optional feature, REG_TEXT_HILITE_EN defined: snapshot R2 = 0x00A0, then snapshot R2 = 0x00B0 -> after the second snapshot, rd_hilite=1 only at (2,6); after a third identical snapshot, all flags are 0.
